// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: producer/consumer handshake, status and SRAM pin bundle.
interface sram_fifo_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              flush;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_in_data;
  logic              sram_wen;
  logic              sram_oen;
  logic [DATA_W-1:0] sram_out_data;
  modport slave (
    input  flush, wr_valid, wr_data, rd_req, sram_out_data,
    output wr_ready, rd_ready, rd_valid, rd_data, count, full, empty,
           sram_addr, sram_in_data, sram_wen, sram_oen
  );
  modport master (
    output flush, wr_valid, wr_data, rd_req, sram_out_data,
    input  wr_ready, rd_ready, rd_valid, rd_data, count, full, empty,
           sram_addr, sram_in_data, sram_wen, sram_oen
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: arbitrates one SRAM port between a byte writer and reader as a wrap-around FIFO.
module sram_fifo_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            n_rst,
  sram_fifo_ctrl_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;
  typedef enum logic {G_READ, G_WRITE} grant_e;
  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, rd_data_q, rd_data_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              full, empty, wr_elig, rd_elig, grant_w, grant_r;
  always_comb begin
    full         = count_q == CW'(DEPTH);
    empty        = count_q == '0;
    wr_elig      = bus.wr_valid && !full;
    rd_elig      = bus.rd_req && !empty;
    grant_w      = n_rst && !bus.flush && wr_elig && (!rd_elig || last_grant_q == G_READ);
    grant_r      = n_rst && !bus.flush && rd_elig && !grant_w;
    // the fairness flag only moves when both sides actually competed
    last_grant_d = (wr_elig && rd_elig && (grant_w || grant_r)) ? (grant_w ? G_WRITE : G_READ) : last_grant_q;
    wptr_d       = bus.flush ? '0 : wptr_q + ADDR_W'(grant_w);
    rptr_d       = bus.flush ? '0 : rptr_q + ADDR_W'(grant_r);
    count_d      = bus.flush ? '0 : count_q + CW'(grant_w) - CW'(grant_r);
    wr_addr_d    = grant_w ? wptr_q : wr_addr_q;
    wr_data_d    = grant_w ? bus.wr_data : wr_data_q;
    rd_addr_d    = grant_r ? rptr_q : rd_addr_q;
    state_d      = grant_w ? WRITE : grant_r ? READ : IDLE;
    rd_valid_d   = state_q == READ && !bus.flush;
    rd_data_d    = rd_valid_d ? bus.sram_out_data : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      last_grant_q <= G_READ;
      wptr_q       <= '0;
      rptr_q       <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_data_q    <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_data_q    <= wr_data_d;
      rd_data_q    <= rd_data_d;
      count_q      <= count_d;
      rd_valid_q   <= rd_valid_d;
    end
  end
  assign bus.wr_ready     = grant_w;
  assign bus.rd_ready     = grant_r;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.sram_wen     = state_q == WRITE;
  assign bus.sram_oen     = state_q == READ;
  assign bus.sram_addr    = state_q == WRITE ? wr_addr_q : state_q == READ ? rd_addr_q : '0;
  assign bus.sram_in_data = state_q == WRITE ? wr_data_q : '0;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: vector table plus directed fill, wrap, conflict, reset and flush sequences.
module tb_sram_fifo_ctrl;
  logic clk = 1'b0;
  logic n_rst;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] mem [1024];
  logic [7:0] got [$];
  logic [9:0] waddr [$];
  sram_fifo_ctrl_if bus ();
  sram_fifo_ctrl dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_in_data;
  assign bus.sram_out_data = bus.sram_oen ? mem[bus.sram_addr] : 8'h00;
  always @(negedge clk) begin
    if (bus.rd_valid) got.push_back(bus.rd_data);
    if (bus.sram_wen) waddr.push_back(bus.sram_addr);
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  typedef struct {
    logic fl, wv; logic [7:0] wd; logic rq;
    logic wrr, rdr; logic [10:0] cnt; logic wen, oen; logic [9:0] addr;
    logic [7:0] din; logic rv; logic [7:0] rdat;
  } vec_t;
  vec_t tbl [14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    bus.wr_valid = 0; bus.rd_req = 0; bus.flush = 0;
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    n_rst = 0; bus.flush = 0; bus.wr_valid = 0; bus.wr_data = 0; bus.rd_req = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1;
  endtask
  task automatic do_writes(input int n, input logic [7:0] seed);
    int miss = 0;
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1; bus.wr_data = 8'(seed + i);
      #1;
      if (!bus.wr_ready) miss++;
      tick();
    end
    bus.wr_valid = 0;
    chk("wr_ready_run_misses", miss, 0);
  endtask
  task automatic do_reads(input int n);
    int miss = 0;
    for (int i = 0; i < n; i++) begin
      bus.rd_req = 1;
      #1;
      if (!bus.rd_ready) miss++;
      tick();
    end
    bus.rd_req = 0;
    chk("rd_ready_run_misses", miss, 0);
  endtask
  task automatic chk_got(input string nm, input int n, input logic [7:0] seed);
    int bad = 0;
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(seed + i)) bad++;
    chk({nm, "_bad_bytes"}, bad, 0);
  endtask
  initial begin
    tbl[0]  = '{0,1,8'hA5,0, 1,0,0,0,0,0,8'h00,0,8'h00};
    tbl[1]  = '{0,0,8'h00,1, 0,1,1,1,0,0,8'hA5,0,8'h00};
    tbl[2]  = '{0,0,8'h00,0, 0,0,0,0,1,0,8'h00,0,8'h00};
    tbl[3]  = '{0,0,8'h00,0, 0,0,0,0,0,0,8'h00,1,8'hA5};
    tbl[4]  = '{0,0,8'h00,1, 0,0,0,0,0,0,8'h00,0,8'hA5};
    tbl[5]  = '{0,0,8'h00,0, 0,0,0,0,0,0,8'h00,0,8'hA5};
    tbl[6]  = '{0,1,8'h11,1, 1,0,0,0,0,0,8'h00,0,8'hA5};
    tbl[7]  = '{0,1,8'h22,1, 1,0,1,1,0,1,8'h11,0,8'hA5};
    tbl[8]  = '{0,1,8'h33,1, 0,1,2,1,0,2,8'h22,0,8'hA5};
    tbl[9]  = '{0,1,8'h33,1, 1,0,1,0,1,1,8'h00,0,8'hA5};
    tbl[10] = '{0,0,8'h00,0, 0,0,2,1,0,3,8'h33,1,8'h11};
    tbl[11] = '{0,0,8'h00,0, 0,0,2,0,0,0,8'h00,0,8'h11};
    tbl[12] = '{1,1,8'h44,1, 0,0,2,0,0,0,8'h00,0,8'h11};
    tbl[13] = '{0,0,8'h00,0, 0,0,0,0,0,0,8'h00,0,8'h11};
    do_reset();
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_wen", bus.sram_wen, 0);
    chk("rst_oen", bus.sram_oen, 0);
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    for (int i = 0; i < 14; i++) begin
      bus.flush = tbl[i].fl; bus.wr_valid = tbl[i].wv; bus.wr_data = tbl[i].wd; bus.rd_req = tbl[i].rq;
      #1;
      chk($sformatf("v%0d_wr_ready", i), bus.wr_ready, tbl[i].wrr);
      chk($sformatf("v%0d_rd_ready", i), bus.rd_ready, tbl[i].rdr);
      chk($sformatf("v%0d_count", i), bus.count, tbl[i].cnt);
      chk($sformatf("v%0d_empty", i), bus.empty, tbl[i].cnt == 0);
      chk($sformatf("v%0d_wen", i), bus.sram_wen, tbl[i].wen);
      chk($sformatf("v%0d_oen", i), bus.sram_oen, tbl[i].oen);
      chk($sformatf("v%0d_addr", i), bus.sram_addr, tbl[i].addr);
      if (tbl[i].wen || !tbl[i].oen) chk($sformatf("v%0d_in_data", i), bus.sram_in_data, tbl[i].din);
      chk($sformatf("v%0d_rd_valid", i), bus.rd_valid, tbl[i].rv);
      chk($sformatf("v%0d_rd_data", i), bus.rd_data, tbl[i].rdat);
      tick();
    end
    idle(2);
    // fill to full, probe the rejected extra write, then drain in order
    do_reset();
    do_writes(1024, 8'h00);
    bus.wr_valid = 1; bus.wr_data = 8'hEE;
    #1;
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 1024);
    chk("fill_extra_wr_ready", bus.wr_ready, 0);
    bus.wr_valid = 0;
    got.delete();
    do_reads(1024);
    idle(3);
    chk_got("fill_read", 1024, 8'h00);
    chk("fill_empty", bus.empty, 1);
    // wrap-around of both pointers
    do_reset();
    do_writes(1000, 8'h37);
    got.delete();
    do_reads(1000);
    idle(3);
    chk_got("wrap_first", 1000, 8'h37);
    got.delete();
    waddr.delete();
    do_writes(50, 8'hC0);
    idle(2);
    begin
      int bad = 0;
      chk("wrap_waddr_count", waddr.size(), 50);
      for (int i = 0; i < waddr.size(); i++) if (waddr[i] !== 10'((1000 + i) % 1024)) bad++;
      chk("wrap_waddr_bad", bad, 0);
    end
    do_reads(50);
    idle(3);
    chk_got("wrap_second", 50, 8'hC0);
    // conflict alternation from count 5
    do_reset();
    do_writes(5, 8'h60);
    got.delete();
    for (int k = 0; k < 6; k++) begin
      bus.wr_valid = 1; bus.wr_data = 8'(8'h70 + k); bus.rd_req = 1;
      #1;
      chk($sformatf("conf%0d_wr_ready", k), bus.wr_ready, k % 2 == 0);
      chk($sformatf("conf%0d_rd_ready", k), bus.rd_ready, k % 2 == 1);
      chk($sformatf("conf%0d_count", k), bus.count, (k % 2 == 1) ? 6 : 5);
      tick();
    end
    idle(3);
    chk_got("conf_read", 3, 8'h60);
    // reset while a WRITE is on the pins
    bus.wr_valid = 1; bus.wr_data = 8'h99;
    #1;
    chk("rstw_accept", bus.wr_ready, 1);
    tick();
    n_rst = 0;
    #1;
    chk("rstw_wen_in_flight", bus.sram_wen, 1);
    chk("rstw_wr_ready_in_reset", bus.wr_ready, 0);
    tick();
    n_rst = 1; bus.wr_valid = 0;
    #1;
    chk("rstw_count", bus.count, 0);
    chk("rstw_empty", bus.empty, 1);
    chk("rstw_full", bus.full, 0);
    chk("rstw_wen", bus.sram_wen, 0);
    chk("rstw_oen", bus.sram_oen, 0);
    chk("rstw_addr", bus.sram_addr, 0);
    chk("rstw_rd_valid", bus.rd_valid, 0);
    chk("rstw_rd_data", bus.rd_data, 0);
    // flush during a READ cycle with count 3
    got.delete();
    do_writes(4, 8'hB0);
    bus.rd_req = 1;
    #1;
    chk("fl_rd_accept", bus.rd_ready, 1);
    tick();
    bus.rd_req = 0; bus.flush = 1;
    #1;
    chk("fl_oen", bus.sram_oen, 1);
    chk("fl_count_before", bus.count, 3);
    tick();
    bus.flush = 0;
    #1;
    chk("fl_count", bus.count, 0);
    chk("fl_empty", bus.empty, 1);
    chk("fl_rd_valid", bus.rd_valid, 0);
    tick();
    chk("fl_rd_valid_late", bus.rd_valid, 0);
    chk("fl_no_data", got.size(), 0);
    do_writes(1, 8'hEE);
    do_reads(1);
    idle(3);
    chk_got("fl_after", 1, 8'hEE);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Single-port FIFO controller that sits directly upstream of the 1024 x 8 address-mapped SRAM and drives its address, data-in, write-enable and output-enable pins. It turns a byte-stream producer and a byte-stream consumer, each with a valid/ready handshake, into ordered single-cycle SRAM accesses. It arbitrates the one SRAM port between writer and reader and tracks occupancy with wrap-around pointers.

## Interface
- DEPTH, 1024, number of SRAM entries; power of two.
- ADDR_W, 10, log2(DEPTH).
- DATA_W, 8, byte width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- flush  in  1  synchronous clear of pointers, count and pipeline.
- wr_valid  in  1  producer has a byte on wr_data.
- wr_data  in  DATA_W  byte to store.
- wr_ready  out  1  write accepted this cycle when high together with wr_valid.
- rd_req  in  1  consumer requests one byte.
- rd_ready  out  1  read accepted this cycle when high together with rd_req.
- rd_valid  out  1  one-cycle pulse: rd_data holds the byte.
- rd_data  out  DATA_W  read byte; holds its value until the next rd_valid.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- sram_addr  out  ADDR_W  SRAM address.
- sram_in_data  out  DATA_W  SRAM write data.
- sram_wen  out  1  SRAM write enable.
- sram_oen  out  1  SRAM output enable.
- sram_out_data  in  DATA_W  SRAM read data; valid in the same cycle that sram_oen is high.

## Operation
- FSM states:
  - IDLE: no access; wen=0, oen=0.
  - WRITE: wen=1, oen=0, addr=wr_addr_q, in_data=wr_data_q.
  - READ: oen=1, wen=0, addr=rd_addr_q.
  - SRAM pins are decoded from state only. In IDLE, sram_addr=0 and sram_in_data=0.
- Eligibility: a write is eligible when wr_valid=1 and full=0. A read is eligible when rd_req=1 and empty=0.
- Acceptance happens in any state; at most one request is accepted per cycle.
- If only one request is eligible, it is granted.
- If both are eligible, grant the opposite of the last conflict winner. A last_grant flag is updated only on conflicts; after reset last_grant=READ, so the first conflict goes to the write.
- wr_ready=1 only in cycles where the write is granted. rd_ready=1 only in cycles where the read is granted. Both are 0 while flush=1 or n_rst=0.
- Write accept:
  - wr_data_q <= wr_data, wr_addr_q <= wptr, wptr <= wptr+1 (mod DEPTH), count +1.
  - Next state is WRITE.
- Read accept:
  - rd_addr_q <= rptr, rptr <= rptr+1 (mod DEPTH), count -1.
  - Next state is READ.
- No accept: next state is IDLE.
- READ-state capture: on the edge that ends a READ cycle, rd_data <= sram_out_data and rd_valid <= 1. Otherwise rd_valid <= 0.
- Pointers are ADDR_W bits and wrap from DEPTH-1 to 0. count is ADDR_W+1 bits, so full and empty are unambiguous.
- Ordering: a write accepted in cycle N is committed in cycle N+1. A read accepted in cycle N+1 therefore returns that byte.
- flush=1:
  - On the next edge: wptr, rptr and count go to 0, state goes to IDLE, rd_valid goes to 0.
  - An access already in WRITE or READ during the flush cycle still drives the SRAM pins that cycle, but its result is discarded.
  - n_rst has priority over flush.

## Timing
- Reset (n_rst=0 at an edge):
  - State IDLE; wptr, rptr, count, wr_addr_q, rd_addr_q, wr_data_q = 0; rd_data=0; last_grant=READ.
  - Resulting outputs: rd_valid=0, empty=1, full=0, sram_wen=0, sram_oen=0, sram_addr=0.
- Write latency: accept edge N, SRAM write during cycle N+1.
- Read latency: accept edge N, sram_oen during cycle N+1, rd_valid=1 during cycle N+2.
- Throughput: one access per cycle. Back-to-back accepts chain WRITE→WRITE, READ→WRITE, etc. with no IDLE gap.
- count, full and empty update on the edge after acceptance.
- Reset mid-operation:
  - Any pending WRITE or READ is abandoned and no rd_valid is produced.
  - SRAM contents are not cleared by this block.

## Test plan
- Reset then single byte: write 0xA5, then rd_req → sram_wen=1 with addr=0 one cycle after the write accept; rd_valid=1 with rd_data=0xA5 two cycles after the read accept; count goes 0→1→0.
- Fill to full: 1024 consecutive writes of i[7:0] → full=1 and count=1024; a 1025th wr_valid sees wr_ready=0. Then 1024 reads return 0x00..0xFF repeating in order and end with empty=1.
- Wrap-around: write 1000 bytes, read 1000, write 50 more → the writes use sram_addr 1000..1023 then 0..25; the reads return the correct bytes.
- Conflict: count=5, wr_valid and rd_req held high together → grants alternate W,R,W,R starting with W after reset; count stays between 5 and 6.
- Empty/full edges: rd_req with empty=1 → rd_ready=0 and no rd_valid. Write and read requested together when count=0 → write granted only.
- Flush and reset: flush during a READ cycle with count=3 → no rd_valid, count=0, empty=1. n_rst=0 during a WRITE → all outputs at reset values on the next cycle.
